seq_pattern_tx: RTL and testbench
=================================

// Module: seq_pattern_tx
// PURPOSE
//   Serial pattern transmitter, the source end of the team's serial sequence-detect link.
//   Loads a PAT_W-bit pattern over a valid/ready handshake and shifts it out MSB-first, one bit per clk.
//   Repeats the pattern a programmed number of times, with a programmable idle gap between repetitions.
//   Drives stimulus streams into downstream serial pattern detectors.
// PARAMETERS
//   PAT_W     4        pattern width in bits (>=2)
//   CNT_W     4        width of the repeat and gap count fields
//   IDLE_BIT  1'b0     level driven on ser_out when not transmitting
// PORTS
//   clk          in   1      clock, rising edge
//   reset        in   1      synchronous, active-high
//   start_valid  in   1      request to start a burst; pat_in, rep_cnt and gap_cnt are valid
//   start_ready  out  1      block is able to accept a burst (high only in IDLE)
//   pat_in       in   PAT_W  pattern to send, bit PAT_W-1 goes first
//   rep_cnt      in   CNT_W  number of repetitions; 0 is treated as 1
//   gap_cnt      in   CNT_W  idle cycles between repetitions; 0 means back-to-back
//   abort        in   1      terminate the burst in progress
//   ser_out      out  1      serial data bit
//   ser_valid    out  1      ser_out carries a pattern bit this cycle
//   busy         out  1      a burst is in progress (SHIFT or GAP state)
//   done         out  1      one-cycle pulse after a burst completes normally
// BEHAVIOUR
//   Reset values: state=IDLE, ser_out=IDLE_BIT, ser_valid=0, busy=0, done=0, start_ready=1.
//   All outputs come from registers. There is no combinational path from any input to any output.
//   States: IDLE, SHIFT, GAP, DONE.
//   IDLE
//     start_ready=1.
//     On start_valid&&start_ready at edge N, the block latches pat_in into shreg, sets reps_left=max(rep_cnt,1), latches gap_cnt and sets bit_idx=PAT_W-1.
//     The next state is SHIFT, so the first bit appears on ser_out in cycle N+1.
//   SHIFT
//     ser_out=shreg[PAT_W-1], ser_valid=1. shreg shifts left each cycle and bit_idx decrements.
//     On the last bit (bit_idx==0) the transition depends on reps_left:
//       reps_left==1 -> DONE.
//       reps_left>1 and gap==0 -> reload shreg from the latched pattern, decrement reps_left, stay in SHIFT. There is no bubble.
//       reps_left>1 and gap>0 -> GAP with gap_left=gap, decrement reps_left.
//   GAP
//     ser_out=IDLE_BIT, ser_valid=0.
//     Stays for exactly gap cycles, then reloads shreg and goes to SHIFT.
//   DONE
//     done=1 for exactly one cycle, start_ready=0, then IDLE.
//   Burst length: the stream holds max(rep_cnt,1)*PAT_W valid bits and (reps-1)*gap idle cycles.
//     done is asserted on the cycle after the last valid bit.
//   abort
//     In SHIFT or GAP, the next state is IDLE. ser_valid falls on the next cycle, ser_out=IDLE_BIT, and done is NOT pulsed.
//     abort is ignored in IDLE and DONE.
//   Priority: reset > abort > normal sequencing.
//   Inputs are sampled only at the accepting handshake edge. Changes to pat_in, rep_cnt or gap_cnt during a burst have no effect.
//   start_valid asserted while busy is not accepted. The requester holds it until start_ready is high.
//   Reset mid-burst returns to IDLE on the next edge. No done pulse, all outputs take their reset values.
//   Counter widths: reps_left and gap_left are CNT_W bits, bit_idx is $clog2(PAT_W) bits.
//     No counter ever wraps, because a transition happens at 0/1 before any further decrement.
// STRUCTURE
//   Package seq_pkg holds:
//     the state enum seq_tx_state_t {IDLE, SHIFT, GAP, DONE},
//     the localparam DEFAULT_PAT_1010 = 4'b1010 used by the benches.
//   One sub-module, seq_down_cnt (a loadable down-counter with a zero flag).
//     It is instantiated twice: once for reps_left and once for gap_left.
//   The FSM, the shift register and bit_idx live in this module.
// TESTING
//   1 Reset, then pat=1010, rep=1, gap=0. Expected: ser_out=1,0,1,0 in cycles N+1..N+4, ser_valid=1 for those 4 cycles only,
//     done pulse in cycle N+5, start_ready back to 1 in cycle N+6.
//   2 pat=1010, rep=3, gap=0, with ser_out fed into an overlapping 1010 detector model.
//     Expected: 12 contiguous valid bits 101010101010, the detector fires 5 times (after bits 4,6,8,10,12), one done pulse.
//   3 pat=1010, rep=2, gap=2. Expected: valid 1010, then 2 cycles of ser_valid=0 with ser_out=0, then valid 1010, then done.
//     Total 10 cycles from the first bit to done.
//   4 rep=0 is treated as 1: one 4-bit burst and a done pulse.
//     start_valid held during the burst is not accepted until start_ready=1, and the new pattern is then sent intact.
//   5 abort in the 2nd SHIFT cycle of a rep=3 burst. Expected: IDLE on the next edge, no done pulse, ser_valid=0, start_ready=1.
//     Repeat the check with reset asserted in GAP: all outputs take their reset values on the next edge.
//   6 pat_in and rep_cnt changed mid-burst (pat 1010 -> 0110). The output stream still carries the originally latched 1010.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and constants for the serial sequence-detect link.
//   seq_tx_state_t   : transmitter FSM states
//   DEFAULT_PAT_1010 : the canonical 4-bit pattern the link is exercised with
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP,
    DONE
  } seq_tx_state_t;

  localparam logic [3:0] DEFAULT_PAT_1010 = 4'b1010;

endpackage

// File: rtl/seq_down_cnt.sv
// Loadable down-counter with a zero flag.
//   clk      : clock, rising edge
//   reset    : synchronous, active-high, clears the count
//   load     : load load_val (wins over dec)
//   load_val : value to load
//   dec      : decrement by one; saturates at zero, never wraps
//   zero     : count is zero
module seq_down_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  // NOTE: sequential state is written with <= so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: accepts a pattern over valid/ready and sends it
// MSB-first, repeated rep_cnt times with gap_cnt idle cycles in between.
//   clk, reset             : clock and synchronous active-high reset
//   start_valid/ready      : burst request handshake (ready only in IDLE)
//   pat_in                 : pattern, bit PAT_W-1 sent first
//   rep_cnt                : repetitions, 0 behaves as 1
//   gap_cnt                : idle cycles between repetitions
//   abort                  : kill the burst in SHIFT/GAP, no done pulse
//   ser_out, ser_valid     : serial bit and its qualifier
//   busy                   : burst in progress (SHIFT or GAP)
//   done                   : one-cycle pulse after normal completion
// All outputs are registers.
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int   PAT_W    = 4,
  parameter int   CNT_W    = 4,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [PAT_W-1:0] pat_in,
  input  logic [CNT_W-1:0] rep_cnt,
  input  logic [CNT_W-1:0] gap_cnt,
  input  logic             abort,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  localparam int                IDX_W    = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

  seq_tx_state_t    state;
  logic [PAT_W-1:0] pat_reg;   // pattern latched at the handshake
  logic [PAT_W-1:0] shreg;     // bits still to send after the one on ser_out
  logic [CNT_W-1:0] gap_reg;   // gap length latched at the handshake
  logic [IDX_W-1:0] bit_idx;   // index of the bit currently on ser_out

  logic             accept;
  logic             last_bit;
  logic             killed;
  logic             rep_load, rep_dec, rep_zero;
  logic [CNT_W-1:0] rep_load_val;
  logic             gap_load, gap_dec, gap_zero;
  logic [CNT_W-1:0] gap_load_val;

  assign accept   = (state == IDLE) && start_valid;
  assign last_bit = (state == SHIFT) && (bit_idx == '0);
  assign killed   = abort && ((state == SHIFT) || (state == GAP));

  // The reps counter holds reps_left-1, so its zero flag marks the final
  // repetition; rep_cnt of 0 loads 0, i.e. a single repetition.
  assign rep_load     = accept;
  assign rep_load_val = (rep_cnt == '0) ? '0 : rep_cnt - 1'b1;
  assign rep_dec      = last_bit && !killed && !rep_zero;

  // The gap counter holds gap_left-1; GAP exits on the cycle it reads zero,
  // giving exactly gap_reg idle cycles.
  assign gap_load     = rep_dec && (gap_reg != '0);
  assign gap_load_val = gap_reg - 1'b1;
  assign gap_dec      = (state == GAP) && !killed && !gap_zero;

  seq_down_cnt #(.W(CNT_W)) u_reps_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (rep_load),
    .load_val (rep_load_val),
    .dec      (rep_dec),
    .zero     (rep_zero)
  );

  seq_down_cnt #(.W(CNT_W)) u_gap_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (gap_load),
    .load_val (gap_load_val),
    .dec      (gap_dec),
    .zero     (gap_zero)
  );

  // ser_out is registered separately from shreg: loading the MSB straight
  // into ser_out at each (re)load puts the first bit on the line in the very
  // next cycle with no bubble between repetitions.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ser_out     <= IDLE_BIT;
      ser_valid   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      start_ready <= 1'b1;
      pat_reg     <= '0;
      shreg       <= '0;
      gap_reg     <= '0;
      bit_idx     <= '0;
    end else if (killed) begin
      state       <= IDLE;
      ser_out     <= IDLE_BIT;
      ser_valid   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      start_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            state       <= SHIFT;
            pat_reg     <= pat_in;
            gap_reg     <= gap_cnt;
            shreg       <= pat_in << 1;
            ser_out     <= pat_in[PAT_W-1];
            ser_valid   <= 1'b1;
            bit_idx     <= LAST_IDX;
            busy        <= 1'b1;
            start_ready <= 1'b0;
          end
        end

        SHIFT: begin
          if (bit_idx != '0) begin
            ser_out <= shreg[PAT_W-1];
            shreg   <= shreg << 1;
            bit_idx <= bit_idx - 1'b1;
          end else if (rep_zero) begin
            state     <= DONE;
            ser_out   <= IDLE_BIT;
            ser_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else if (gap_reg == '0) begin
            ser_out <= pat_reg[PAT_W-1];
            shreg   <= pat_reg << 1;
            bit_idx <= LAST_IDX;
          end else begin
            state     <= GAP;
            ser_out   <= IDLE_BIT;
            ser_valid <= 1'b0;
          end
        end

        GAP: begin
          if (gap_zero) begin
            state     <= SHIFT;
            ser_out   <= pat_reg[PAT_W-1];
            ser_valid <= 1'b1;
            shreg     <= pat_reg << 1;
            bit_idx   <= LAST_IDX;
          end
        end

        DONE: begin
          state       <= IDLE;
          done        <= 1'b0;
          start_ready <= 1'b1;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx. A per-cycle expected trace is built
// from the burst rules (bits, gaps, done, ready) and compared to the outputs
// sampled on the falling edge.
module tb_seq_pattern_tx;
  import seq_pkg::*;

  localparam int PAT_W = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             start_valid;
  logic             start_ready;
  logic [PAT_W-1:0] pat_in;
  logic [CNT_W-1:0] rep_cnt;
  logic [CNT_W-1:0] gap_cnt;
  logic             abort;
  logic             ser_out;
  logic             ser_valid;
  logic             busy;
  logic             done;

  seq_pattern_tx #(.PAT_W(PAT_W), .CNT_W(CNT_W), .IDLE_BIT(1'b0)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .pat_in      (pat_in),
    .rep_cnt     (rep_cnt),
    .gap_cnt     (gap_cnt),
    .abort       (abort),
    .ser_out     (ser_out),
    .ser_valid   (ser_valid),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // One sampled cycle: valid, out, done, busy, ready.
  typedef struct packed {
    logic v;
    logic o;
    logic d;
    logic b;
    logic r;
  } obs_t;

  localparam obs_t IDLE_OBS = obs_t'{v: 1'b0, o: 1'b0, d: 1'b0, b: 1'b0, r: 1'b1};

  int   checks = 0;
  int   errors = 0;
  obs_t exp_q[$];
  obs_t got_q[$];

  // Expected trace from the cycle after the accepting edge up to and
  // including the first cycle with start_ready high again.
  task automatic model_burst(input logic [PAT_W-1:0] pat, input int rep, input int gap);
    int reps;
    reps = (rep == 0) ? 1 : rep;
    for (int r = 0; r < reps; r++) begin
      for (int i = PAT_W - 1; i >= 0; i--)
        exp_q.push_back(obs_t'{v: 1'b1, o: pat[i], d: 1'b0, b: 1'b1, r: 1'b0});
      if (r < reps - 1)
        for (int g = 0; g < gap; g++)
          exp_q.push_back(obs_t'{v: 1'b0, o: 1'b0, d: 1'b0, b: 1'b1, r: 1'b0});
    end
    exp_q.push_back(obs_t'{v: 1'b0, o: 1'b0, d: 1'b1, b: 1'b0, r: 1'b0});
    exp_q.push_back(IDLE_OBS);
  endtask

  task automatic capture(input int n);
    repeat (n) begin
      @(negedge clk);
      got_q.push_back(obs_t'{v: ser_valid, o: ser_out, d: done, b: busy, r: start_ready});
    end
  endtask

  // Waits (bounded) for start_ready, presents a request and returns just
  // after the accepting edge with start_valid dropped.
  task automatic do_start(input logic [PAT_W-1:0] pat, input int rep, input int gap);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!start_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (start_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_wait ready=%b required 1 after %0d cycles", start_ready, waited);
    end
    pat_in      = pat;
    rep_cnt     = CNT_W'(rep);
    gap_cnt     = CNT_W'(gap);
    start_valid = 1'b1;
    @(posedge clk);
    #1 start_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (obs_t'{v: ser_valid, o: ser_out, d: done, b: busy, r: start_ready} !== IDLE_OBS) begin
      errors++;
      $display("FAIL reset_values got vodbr=%b required %b",
               obs_t'{v: ser_valid, o: ser_out, d: done, b: busy, r: start_ready}, IDLE_OBS);
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    exp_q.delete(); got_q.delete();
    model_burst(DEFAULT_PAT_1010, 1, 0);
    do_start(DEFAULT_PAT_1010, 1, 0);
    capture(exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL single cycle %0d got vodbr=%b required %b", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] win;
    int nbits, hits;
    int hit_pos[$];
    exp_q.delete(); got_q.delete();
    model_burst(DEFAULT_PAT_1010, 3, 0);
    do_start(DEFAULT_PAT_1010, 3, 0);
    capture(exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL back_to_back cycle %0d got vodbr=%b required %b", i, got_q[i], exp_q[i]);
      end
    end
    // Overlapping 1010 detector over the valid bits actually transmitted.
    win = '0; nbits = 0; hits = 0;
    foreach (got_q[i]) begin
      if (got_q[i].v) begin
        win = {win[2:0], got_q[i].o};
        nbits++;
        if (nbits >= 4 && win == 4'b1010) begin
          hits++;
          hit_pos.push_back(nbits);
        end
      end
    end
    checks++;
    if (hits != 5 || nbits != 12) begin
      errors++;
      $display("FAIL detector hits=%0d bits=%0d required hits=5 bits=12", hits, nbits);
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (hit_pos[k] != 4 + 2 * k) begin
          errors++;
          $display("FAIL detector_pos hit %0d at bit %0d required %0d", k, hit_pos[k], 4 + 2 * k);
        end
      end
    end
  endtask

  task automatic test_gap();
    int done_at;
    exp_q.delete(); got_q.delete();
    model_burst(DEFAULT_PAT_1010, 2, 2);
    do_start(DEFAULT_PAT_1010, 2, 2);
    capture(exp_q.size());
    done_at = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL gap cycle %0d got vodbr=%b required %b", i, got_q[i], exp_q[i]);
      end
      if (got_q[i].d && done_at < 0) done_at = i;
    end
    // 4 bits + 2 gap + 4 bits occupy cycles 0..9, done follows in cycle 10.
    checks++;
    if (done_at != 10) begin
      errors++;
      $display("FAIL gap_done_cycle got %0d required 10", done_at);
    end
  endtask

  task automatic test_rep0_and_hold();
    logic [PAT_W-1:0] pat_b;
    pat_b = 4'b0110;
    exp_q.delete(); got_q.delete();
    model_burst(4'b1101, 0, 3);
    do_start(4'b1101, 0, 3);
    // Second request presented immediately and held through the burst.
    pat_in = pat_b; rep_cnt = 4'd1; gap_cnt = 4'd0; start_valid = 1'b1;
    capture(exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rep0 cycle %0d got vodbr=%b required %b", i, got_q[i], exp_q[i]);
      end
    end
    @(posedge clk);
    #1 start_valid = 1'b0;
    exp_q.delete(); got_q.delete();
    model_burst(pat_b, 1, 0);
    capture(exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL held_start cycle %0d got vodbr=%b required %b", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_abort();
    obs_t now;
    do_start(DEFAULT_PAT_1010, 3, 0);
    @(negedge clk);               // first SHIFT cycle
    @(negedge clk);               // second SHIFT cycle
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    got_q.delete();
    capture(5);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (got_q[i] !== IDLE_OBS) begin
        errors++;
        $display("FAIL abort cycle %0d got vodbr=%b required %b", i, got_q[i], IDLE_OBS);
      end
    end

    // Reset while sitting in the gap between repetitions.
    do_start(4'b1001, 2, 3);
    repeat (5) @(negedge clk);    // 4 bits then first GAP cycle
    now = obs_t'{v: ser_valid, o: ser_out, d: done, b: busy, r: start_ready};
    checks++;
    if (now !== obs_t'{v: 1'b0, o: 1'b0, d: 1'b0, b: 1'b1, r: 1'b0}) begin
      errors++;
      $display("FAIL in_gap got vodbr=%b required 00010", now);
    end
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    got_q.delete();
    capture(5);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (got_q[i] !== IDLE_OBS) begin
        errors++;
        $display("FAIL reset_in_gap cycle %0d got vodbr=%b required %b", i, got_q[i], IDLE_OBS);
      end
    end
  endtask

  task automatic test_input_change();
    exp_q.delete(); got_q.delete();
    model_burst(DEFAULT_PAT_1010, 2, 1);
    do_start(DEFAULT_PAT_1010, 2, 1);
    pat_in = 4'b0110; rep_cnt = 4'd3; gap_cnt = 4'd0;
    capture(exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL input_change cycle %0d got vodbr=%b required %b", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [PAT_W-1:0] pat;
    int rep, gap;
    for (int k = 0; k < 12; k++) begin
      pat = PAT_W'($urandom);
      rep = int'($urandom_range(0, 4));
      gap = int'($urandom_range(0, 3));
      exp_q.delete(); got_q.delete();
      model_burst(pat, rep, gap);
      do_start(pat, rep, gap);
      pat_in = PAT_W'($urandom); rep_cnt = CNT_W'($urandom); gap_cnt = CNT_W'($urandom);
      capture(exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL random burst %0d (pat=%b rep=%0d gap=%0d) cycle %0d got vodbr=%b required %b",
                   k, pat, rep, gap, i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; start_valid = 1'b0; abort = 1'b0;
    pat_in = '0; rep_cnt = '0; gap_cnt = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_gap();
    test_rep0_and_hold();
    test_abort();
    test_input_change();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
